// File: rtl/trace_filter_if.sv
// Tracer-facing handshake: head entry of the trace FIFO offered with valid/ready.
interface trace_filter_if;
  logic        valid;
  logic [63:0] pc;
  logic [31:0] inst;
  logic        jmp;
  logic        ready;

  modport master (output valid, pc, inst, jmp, input ready);
  modport slave  (input valid, pc, inst, jmp, output ready);
endinterface

// File: rtl/trace_filter.sv
// Filters the non-stallable commit stream by enable and PC window, tags discontinuities
// and buffers entries for the tracer; overflowing commits are dropped and counted.
module trace_filter #(
  parameter int BUF_DEPTH  = 4,
  parameter int INST_BYTES = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           trace_en,
  input  logic [63:0]    win_lo,
  input  logic [63:0]    win_hi,
  input  logic           commit_valid,
  input  logic [63:0]    commit_pc,
  input  logic [31:0]    commit_inst,
  trace_filter_if.master trc,
  output logic [31:0]    drop_cnt,
  output logic           overflow
);
  localparam int          PW       = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(BUF_DEPTH);
  localparam logic [63:0] STEP     = 64'(INST_BYTES);

  logic [63:0]          r_mem_pc   [BUF_DEPTH];
  logic [31:0]          r_mem_inst [BUF_DEPTH];
  logic [BUF_DEPTH-1:0] r_mem_jmp;
  logic [PW-1:0]        r_wr_ptr;
  logic [PW-1:0]        r_rd_ptr;
  logic [PW:0]          r_count;
  logic [63:0]          r_prev_pc;
  logic                 r_first;
  logic                 r_gap;
  logic [31:0]          r_drop_cnt;
  logic                 r_overflow;

  logic w_cand;
  logic w_seq;
  logic w_jmp;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign w_cand = commit_valid && trace_en && (commit_pc >= win_lo) && (commit_pc <= win_hi);
  // 64-bit add wraps, so the top-of-space to zero transition counts as sequential
  assign w_seq  = (commit_pc == r_prev_pc + STEP);
  assign w_jmp  = r_first || r_gap || !w_seq;
  assign w_full = (r_count == FULL_CNT);
  assign w_pop  = trc.valid && trc.ready;
  assign w_push = w_cand && (!w_full || w_pop);
  assign w_drop = w_cand && w_full && !w_pop;

  // Head fields come straight from storage; a slot is only rewritten while it is not the head.
  assign trc.valid = (r_count != '0);
  assign trc.pc    = r_mem_pc[r_rd_ptr];
  assign trc.inst  = r_mem_inst[r_rd_ptr];
  assign trc.jmp   = r_mem_jmp[r_rd_ptr];
  assign drop_cnt  = r_drop_cnt;
  assign overflow  = r_overflow;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        r_mem_pc[i]   <= '0;
        r_mem_inst[i] <= '0;
      end
      r_mem_jmp  <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_prev_pc  <= '0;
      r_first    <= 1'b1;
      r_gap      <= 1'b0;
      r_drop_cnt <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem_pc[r_wr_ptr]   <= commit_pc;
        r_mem_inst[r_wr_ptr] <= commit_inst;
        r_mem_jmp[r_wr_ptr]  <= w_jmp;
        r_wr_ptr             <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase

      if (commit_valid) begin
        r_prev_pc <= commit_pc;
      end
      // A lost or filtered commit breaks the sequence seen by the tracer
      if (w_push) begin
        r_first <= 1'b0;
        r_gap   <= 1'b0;
      end else if (w_drop || (commit_valid && !w_cand)) begin
        r_gap <= 1'b1;
      end

      if (w_drop) begin
        r_drop_cnt <= sat_inc(r_drop_cnt);
        r_overflow <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_trace_filter.sv
// Bench for trace_filter: directed vector table, reset/saturation sequences and
// randomized traffic against a queue-based reference model.
module tb_trace_filter;
  localparam int          DEPTH = 4;
  localparam logic [63:0] ALL   = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        trace_en = 1'b0;
  logic [63:0] win_lo = '0;
  logic [63:0] win_hi = '0;
  logic        commit_valid = 1'b0;
  logic [63:0] commit_pc = '0;
  logic [31:0] commit_inst = '0;
  logic [31:0] drop_cnt;
  logic        overflow;

  trace_filter_if tif();

  trace_filter #(.BUF_DEPTH(DEPTH), .INST_BYTES(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .trace_en     (trace_en),
    .win_lo       (win_lo),
    .win_hi       (win_hi),
    .commit_valid (commit_valid),
    .commit_pc    (commit_pc),
    .commit_inst  (commit_inst),
    .trc          (tif),
    .drop_cnt     (drop_cnt),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [63:0] p);
    return p[31:0] ^ 32'h5A5A_1234;
  endfunction

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        jmp;
  } ent_t;

  ent_t        mq[$];
  logic [63:0] m_prev;
  bit          m_first;
  bit          m_gap;
  logic [31:0] m_drop;
  bit          m_ovf;

  task automatic model_reset();
    mq.delete();
    m_prev  = '0;
    m_first = 1'b1;
    m_gap   = 1'b0;
    m_drop  = '0;
    m_ovf   = 1'b0;
  endtask

  task automatic model_step(input bit cv, input logic [63:0] pc, input bit en,
                            input logic [63:0] lo, input logic [63:0] hi, input bit rdy);
    bit   in_win;
    ent_t e;
    in_win = cv && en && (pc >= lo) && (pc <= hi);
    if (rdy && mq.size() > 0) mq.delete(0);
    if (in_win) begin
      if (mq.size() < DEPTH) begin
        e.pc   = pc;
        e.inst = enc(pc);
        e.jmp  = m_first || m_gap || (pc != m_prev + 64'd4);
        mq.push_back(e);
        m_first = 1'b0;
        m_gap   = 1'b0;
      end else begin
        if (m_drop != 32'hFFFF_FFFF) m_drop = m_drop + 32'd1;
        m_ovf = 1'b1;
        m_gap = 1'b1;
      end
    end else if (cv) begin
      m_gap = 1'b1;
    end
    if (cv) m_prev = pc;
  endtask

  // Called at a falling edge; applies inputs for one cycle, returns at the next falling edge.
  task automatic drive(input bit cv, input logic [63:0] pc, input bit en,
                       input logic [63:0] lo, input logic [63:0] hi, input bit rdy);
    commit_valid = cv;
    commit_pc    = pc;
    commit_inst  = enc(pc);
    trace_en     = en;
    win_lo       = lo;
    win_hi       = hi;
    tif.ready    = rdy;
    @(posedge clk);
    model_step(cv, pc, en, lo, hi, rdy);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    commit_valid = 1'b0;
    tif.ready    = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          rst_before;
    bit          cv;
    logic [63:0] pc;
    bit          rdy;
    logic [63:0] lo;
    logic [63:0] hi;
    bit          ev;
    logic [63:0] epc;
    bit          ej;
    logic [31:0] edrop;
    bit          eovf;
  } vec_t;

  function automatic vec_t mk(input bit rb, input bit cv, input logic [63:0] pc, input bit rdy,
                              input logic [63:0] lo, input logic [63:0] hi, input bit ev,
                              input logic [63:0] epc, input bit ej, input logic [31:0] ed,
                              input bit eo);
    vec_t v;
    v.rst_before = rb; v.cv = cv; v.pc = pc; v.rdy = rdy; v.lo = lo; v.hi = hi;
    v.ev = ev; v.epc = epc; v.ej = ej; v.edrop = ed; v.eovf = eo;
    return v;
  endfunction

  vec_t vt[$];

  initial begin
    logic [63:0] rpc;
    logic [63:0] lo;
    logic [63:0] hi;
    bit          cv;
    bit          en;
    bit          rdy;
    int          phase;

    // sequential run with one jump
    vt.push_back(mk(1, 1, 64'h1000, 1, 0, ALL, 1, 64'h1000, 1, 0, 0));
    vt.push_back(mk(0, 1, 64'h1004, 1, 0, ALL, 1, 64'h1004, 0, 0, 0));
    vt.push_back(mk(0, 1, 64'h1008, 1, 0, ALL, 1, 64'h1008, 0, 0, 0));
    vt.push_back(mk(0, 1, 64'h2000, 1, 0, ALL, 1, 64'h2000, 1, 0, 0));
    vt.push_back(mk(0, 0, 64'h0,    1, 0, ALL, 0, 64'h0,    0, 0, 0));
    // address window with gaps
    vt.push_back(mk(0, 1, 64'h0FFC, 1, 64'h1000, 64'h1007, 0, 64'h0,    0, 0, 0));
    vt.push_back(mk(0, 1, 64'h1000, 1, 64'h1000, 64'h1007, 1, 64'h1000, 1, 0, 0));
    vt.push_back(mk(0, 1, 64'h1004, 1, 64'h1000, 64'h1007, 1, 64'h1004, 0, 0, 0));
    vt.push_back(mk(0, 1, 64'h1008, 1, 64'h1000, 64'h1007, 0, 64'h0,    0, 0, 0));
    vt.push_back(mk(0, 1, 64'h100C, 1, 64'h1000, 64'h1007, 0, 64'h0,    0, 0, 0));
    vt.push_back(mk(0, 1, 64'h1000, 1, 64'h1000, 64'h1007, 1, 64'h1000, 1, 0, 0));
    vt.push_back(mk(0, 0, 64'h0,    1, 64'h1000, 64'h1007, 0, 64'h0,    0, 0, 0));
    // overflow with ready low, then full+pop, then drain
    vt.push_back(mk(1, 1, 64'h8000, 0, 0, ALL, 1, 64'h8000, 1, 0, 0));
    vt.push_back(mk(0, 1, 64'h8004, 0, 0, ALL, 1, 64'h8000, 1, 0, 0));
    vt.push_back(mk(0, 1, 64'h8008, 0, 0, ALL, 1, 64'h8000, 1, 0, 0));
    vt.push_back(mk(0, 1, 64'h800C, 0, 0, ALL, 1, 64'h8000, 1, 0, 0));
    vt.push_back(mk(0, 1, 64'h8010, 0, 0, ALL, 1, 64'h8000, 1, 1, 1));
    vt.push_back(mk(0, 1, 64'h8014, 0, 0, ALL, 1, 64'h8000, 1, 2, 1));
    vt.push_back(mk(0, 1, 64'h8018, 1, 0, ALL, 1, 64'h8004, 0, 2, 1));
    vt.push_back(mk(0, 0, 64'h0,    1, 0, ALL, 1, 64'h8008, 0, 2, 1));
    vt.push_back(mk(0, 0, 64'h0,    1, 0, ALL, 1, 64'h800C, 0, 2, 1));
    vt.push_back(mk(0, 0, 64'h0,    1, 0, ALL, 1, 64'h8018, 1, 2, 1));
    vt.push_back(mk(0, 0, 64'h0,    1, 0, ALL, 0, 64'h0,    0, 2, 1));

    // reset state
    tif.ready = 1'b0;
    #2;
    chk("rst_valid", 64'(tif.valid), 0);
    chk("rst_pc",    tif.pc,         0);
    chk("rst_inst",  64'(tif.inst),  0);
    chk("rst_jmp",   64'(tif.jmp),   0);
    chk("rst_drop",  64'(drop_cnt),  0);
    chk("rst_ovf",   64'(overflow),  0);
    @(negedge clk);

    for (int i = 0; i < vt.size(); i++) begin
      if (vt[i].rst_before) do_reset();
      drive(vt[i].cv, vt[i].pc, 1'b1, vt[i].lo, vt[i].hi, vt[i].rdy);
      chk($sformatf("vec%0d_valid", i), 64'(tif.valid), 64'(vt[i].ev));
      if (vt[i].ev) begin
        chk($sformatf("vec%0d_pc", i),   tif.pc,        vt[i].epc);
        chk($sformatf("vec%0d_inst", i), 64'(tif.inst), 64'(enc(vt[i].epc)));
        chk($sformatf("vec%0d_jmp", i),  64'(tif.jmp),  64'(vt[i].ej));
      end
      chk($sformatf("vec%0d_drop", i), 64'(drop_cnt), 64'(vt[i].edrop));
      chk($sformatf("vec%0d_ovf", i),  64'(overflow), 64'(vt[i].eovf));
    end

    // asynchronous reset with three entries held (drop_cnt is 2 from the table)
    drive(1, 64'h9000, 1, 0, ALL, 0);
    drive(1, 64'h9004, 1, 0, ALL, 0);
    drive(1, 64'h9008, 1, 0, ALL, 0);
    commit_valid = 1'b0;
    chk("mid_valid_before", 64'(tif.valid), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_valid", 64'(tif.valid), 0);
    chk("async_drop",  64'(drop_cnt),  0);
    chk("async_ovf",   64'(overflow),  0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    drive(1, 64'h4000, 1, 0, ALL, 1);
    chk("post_rst_valid", 64'(tif.valid), 1);
    chk("post_rst_pc",    tif.pc,         64'h4000);
    chk("post_rst_jmp",   64'(tif.jmp),   1);
    chk("post_rst_drop",  64'(drop_cnt),  0);

    // randomized traffic against the model
    do_reset();
    rpc = 64'h100;
    for (int i = 0; i < 800; i++) begin
      phase = (i / 40) % 4;
      if ((i % 100) < 70)      begin lo = 0;        hi = ALL;      end
      else if ((i % 100) < 90) begin lo = 64'h080;  hi = 64'h17F;  end
      else                     begin lo = 64'h200;  hi = 64'h100;  end
      cv  = ($urandom_range(0, 9) < 7);
      en  = ($urandom_range(0, 9) != 0);
      case (phase)
        0:       rdy = ($urandom_range(0, 3) != 0);
        1:       rdy = ($urandom_range(0, 3) == 0);
        2:       rdy = 1'b0;
        default: rdy = $urandom_range(0, 1) == 1;
      endcase
      if (cv) begin
        if ($urandom_range(0, 31) == 0)     rpc = 64'hFFFF_FFFF_FFFF_FFFC;
        else if ($urandom_range(0, 7) == 0) rpc = 64'($urandom_range(0, 127)) << 2;
        else                                rpc = rpc + 64'd4;
      end
      drive(cv, rpc, en, lo, hi, rdy);
      chk("rnd_valid", 64'(tif.valid), 64'(mq.size() > 0));
      if (mq.size() > 0) begin
        chk("rnd_pc",   tif.pc,        mq[0].pc);
        chk("rnd_inst", 64'(tif.inst), 64'(mq[0].inst));
        chk("rnd_jmp",  64'(tif.jmp),  64'(mq[0].jmp));
      end
      chk("rnd_drop", 64'(drop_cnt), 64'(m_drop));
      chk("rnd_ovf",  64'(overflow), 64'(m_ovf));
    end

    // saturation of the drop counter
    do_reset();
    for (int k = 0; k < DEPTH; k++) drive(1, 64'hA000 + 64'(k * 4), 1, 0, ALL, 0);
    commit_valid = 1'b0;
    force dut.r_drop_cnt = 32'hFFFF_FFFE;
    #1 release dut.r_drop_cnt;
    drive(1, 64'hA010, 1, 0, ALL, 0);
    chk("sat_first", 64'(drop_cnt), 64'hFFFF_FFFF);
    drive(1, 64'hA014, 1, 0, ALL, 0);
    chk("sat_hold",  64'(drop_cnt), 64'hFFFF_FFFF);
    drive(1, 64'hA018, 1, 0, ALL, 0);
    chk("sat_hold2", 64'(drop_cnt), 64'hFFFF_FFFF);
    chk("sat_ovf",   64'(overflow), 1);
    chk("sat_head",  tif.pc,        64'hA000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/trace_filter.md
Name: trace_filter

Overview:
- Upstream feeder of the instruction tracer.
- Samples the core's retired-instruction commit stream, which cannot be stalled, and applies an enable and an address-window filter.
- Marks control-flow discontinuities with the jmp flag and buffers entries in a small FIFO facing the tracer's valid/ready interface.
- When the FIFO is full it drops commits, counts them, and flags the break so the trace output stays self-describing.

Parameters:
- BUF_DEPTH, 4: FIFO entries; power of two, at least 2.
- INST_BYTES, 4: sequential PC increment used for discontinuity detection.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- trace_en  in  1  global enable; when 0, commits are discarded.
- win_lo  in  64  inclusive lower PC bound of the trace window.
- win_hi  in  64  inclusive upper PC bound of the trace window.
- commit_valid  in  1  core retired one instruction this cycle.
- commit_pc  in  64  PC of the retired instruction.
- commit_inst  in  32  encoding of the retired instruction.
- valid  out  1  FIFO head is valid (to tracer).
- pc  out  64  head PC.
- inst  out  32  head instruction.
- jmp  out  1  head is discontinuous with the previously emitted entry.
- ready  in  1  tracer accepts the head this cycle.
- drop_cnt  out  32  number of in-window commits lost to overflow; saturating.
- overflow  out  1  sticky flag: at least one drop since reset.

Behaviour:
- Reset (asynchronous, active-high): FIFO empty, valid=0; pc, inst, jmp = 0; drop_cnt=0; overflow=0; prev_pc=0; first=1; gap=0.
  - Reset asserted mid-operation discards FIFO contents immediately.
- Qualification: cand = commit_valid && trace_en && (commit_pc >= win_lo) && (commit_pc <= win_hi).
  - Comparisons are unsigned.
  - Window inputs are sampled in the commit cycle.
  - win_lo > win_hi makes no commit pass.
- Sequence tracking:
  - prev_pc <= commit_pc on every commit_valid, independent of cand.
  - seq = (commit_pc == prev_pc + INST_BYTES), computed modulo 2^64 so that wrap counts as sequential.
  - gap <= 1 when commit_valid && !cand.
- Entry jmp = first || gap || !seq.
- Push: pop = valid && ready; push = cand && (!full || pop).
  - On push, the entry {commit_pc, commit_inst, jmp} enters the FIFO tail, and first and gap are cleared.
  - The same-cycle gap-set for a non-cand commit has no conflict, since push requires cand.
- Drop: cand && full && !pop.
  - Entry is discarded.
  - drop_cnt increments, holding at 0xFFFF_FFFF.
  - overflow <= 1.
  - gap <= 1, so the next pushed entry carries jmp=1.
- Full with simultaneous pop: push is accepted and occupancy is unchanged.
- Latency: a commit pushed in cycle N into an empty FIFO gives valid=1 and head fields in cycle N+1.
  - Fields are registered and stable while valid && !ready.
- Empty with simultaneous push: no bypass; the entry appears at N+1.
- Pointers wrap modulo BUF_DEPTH; an explicit count register distinguishes full from empty.
- trace_en falling: entries already in the FIFO still drain to the tracer.
- Handshake: valid never drops without a pop. Head fields change only on a pop or on empty-to-nonempty.

Test Plan:
- Reset, trace_en=1, window 0..all-ones, ready=1; commits at pc 0x1000, 0x1004, 0x1008, then 0x2000 -> four outputs, each one cycle after its commit, with jmp = 1, 0, 0, 1.
- Window 0x1000..0x1007; commits at 0x0FFC, 0x1000, 0x1004, 0x1008, 0x100C, 0x1000 -> outputs 0x1000 (jmp=1), 0x1004 (jmp=0), 0x1000 (jmp=1 due to gap); drop_cnt=0.
- ready=0, BUF_DEPTH=4; six sequential in-window commits starting at 0x8000 -> FIFO holds 0x8000..0x800C and drop_cnt=2, overflow=1. Then ready=1 and one commit at 0x8018 -> drain 0x8000..0x800C (jmp 1,0,0,0), then 0x8018 with jmp=1.
- FIFO full, ready=1 and commit in the same cycle -> no drop, occupancy stays 4, and the popped/pushed order is preserved.
- drop_cnt forced to saturation (preload via long ready=0 run or force) -> further drops leave it at 0xFFFF_FFFF.
- Assert rst while the FIFO holds 3 entries and ready=0 -> valid=0 asynchronously; after release, the next commit at 0x4000 is emitted with jmp=1 and drop_cnt=0.
